// File: rtl/binary_mul_pkg.sv
// Shared types and constants for the signed multiplier / accumulator slice.
package binary_mul_pkg;

  localparam int unsigned PROD_W      = 15;
  localparam int unsigned ACC_LEN_DEF = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  // Clamp a signed value into the signed range representable in 'width' bits.
  function automatic logic signed [31:0] sat_clip(input logic signed [31:0] value,
                                                  input int unsigned        width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] res;
    hi  = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (width - 1));
    res = value;
    if (value > hi) res = hi;
    if (value < lo) res = lo;
    return res;
  endfunction

endpackage

// File: rtl/binary_mul_acc_sat.sv
// Combinational clamp of the group total from ACC_W to OUT_W with a clip flag.
// Only present when BINARY_MUL_ACC_SAT_EN is defined.
`ifdef BINARY_MUL_ACC_SAT_EN
module binary_mul_acc_sat
  import binary_mul_pkg::*;
#(
  parameter int unsigned ACC_W = 18,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] sum_o,
  output logic                    sat_o
);

  logic signed [31:0] wide;
  logic signed [31:0] clip;

  always_comb begin
    wide  = 32'(acc_i);
    clip  = sat_clip(wide, OUT_W);
    sum_o = OUT_W'(clip);
    sat_o = (clip != wide);
  end

endmodule
`endif

// File: rtl/binary_mul_acc.sv
// Accumulates groups of ACC_LEN signed products and hands each total out on valid/ready.
// Optional output saturation to OUT_W bits is enabled by BINARY_MUL_ACC_SAT_EN.
module binary_mul_acc
  import binary_mul_pkg::*;
#(
  parameter int unsigned ACC_LEN = ACC_LEN_DEF,
  parameter int unsigned ACC_W   = PROD_W + $clog2(ACC_LEN)
`ifdef BINARY_MUL_ACC_SAT_EN
  ,
  parameter int unsigned OUT_W   = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic signed [PROD_W-1:0] in_prod,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [7:0]               out_cnt,
`ifdef BINARY_MUL_ACC_SAT_EN
  output logic                     out_sat,
  output logic signed [OUT_W-1:0]  out_sum
`else
  output logic signed [ACC_W-1:0]  out_sum
`endif
);

`ifdef BINARY_MUL_ACC_SAT_EN
  localparam int unsigned SUM_W = OUT_W;
`else
  localparam int unsigned SUM_W = ACC_W;
`endif

  acc_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              cnt_q, cnt_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic                    vld_q, vld_d;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [SUM_W-1:0] res_sum;
  logic                    last_c;

  assign acc_nxt = acc_q + ACC_W'(in_prod);
  assign last_c  = (cnt_q == 8'(ACC_LEN - 1));

`ifdef BINARY_MUL_ACC_SAT_EN
  logic sat_q, sat_d;
  logic res_sat;

  binary_mul_acc_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .acc_i (acc_nxt),
    .sum_o (res_sum),
    .sat_o (res_sat)
  );

  assign out_sat = sat_q;
`else
  assign res_sum = acc_nxt;
`endif

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      vld_q   <= 1'b0;
`ifdef BINARY_MUL_ACC_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      vld_q   <= vld_d;
`ifdef BINARY_MUL_ACC_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  // Next-state logic; clr overrides both states and drops any same-cycle product
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    vld_d   = vld_q;
`ifdef BINARY_MUL_ACC_SAT_EN
    sat_d   = sat_q;
`endif
    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      vld_d   = 1'b0;
`ifdef BINARY_MUL_ACC_SAT_EN
      sat_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_vld) begin
            if (last_c) begin
              sum_d   = res_sum;
              acc_d   = '0;
              cnt_d   = '0;
              vld_d   = 1'b1;
              state_d = HOLD;
`ifdef BINARY_MUL_ACC_SAT_EN
              sat_d   = res_sat;
`endif
            end else begin
              acc_d = acc_nxt;
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        HOLD: begin
          if (out_rdy) begin
            state_d = ACCUM;
            vld_d   = 1'b0;
`ifdef BINARY_MUL_ACC_SAT_EN
            sat_d   = 1'b0;
`endif
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign in_rdy  = (state_q == ACCUM);
  assign out_vld = vld_q;
  assign out_cnt = cnt_q;
  assign out_sum = sum_q;

endmodule

// File: tb/tb_binary_mul_acc.sv
// Self-checking bench for binary_mul_acc: directed vector table, async-reset sequences,
// then randomized traffic against a group-sum reference model.
module tb_binary_mul_acc;
  import binary_mul_pkg::*;

  localparam int ACC_LEN = 8;
`ifdef BINARY_MUL_ACC_SAT_EN
  localparam int SUM_W = 16;
`else
  localparam int SUM_W = 18;
`endif

  logic                    clk     = 1'b0;
  logic                    rst_n   = 1'b0;
  logic                    clr     = 1'b0;
  logic                    in_vld  = 1'b0;
  logic                    out_rdy = 1'b0;
  logic signed [14:0]      in_prod = '0;
  logic                    in_rdy;
  logic                    out_vld;
  logic [7:0]              out_cnt;
  logic signed [SUM_W-1:0] out_sum;
`ifdef BINARY_MUL_ACC_SAT_EN
  logic                    out_sat;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  binary_mul_acc #(
    .ACC_LEN (ACC_LEN)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_prod (in_prod),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_cnt (out_cnt),
`ifdef BINARY_MUL_ACC_SAT_EN
    .out_sat (out_sat),
`endif
    .out_sum (out_sum)
  );

  typedef struct {
    logic vld;
    int   prod;
    logic rdy;
    logic clr;
    logic e_vld;
    int   e_cnt;
    int   e_sum;
  } vec_t;

  vec_t vecs[$];

  function automatic int clip(input int v);
`ifdef BINARY_MUL_ACC_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
`endif
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_vld, input int e_cnt, input int e_sum);
    check({tag, "_out_vld"}, int'(out_vld), int'(e_vld));
    check({tag, "_in_rdy"}, int'(in_rdy), int'(!e_vld));
    check({tag, "_out_cnt"}, int'(out_cnt), e_cnt);
    if (e_vld) begin
      check({tag, "_out_sum"}, int'(out_sum), clip(e_sum));
`ifdef BINARY_MUL_ACC_SAT_EN
      check({tag, "_out_sat"}, int'(out_sat), int'(clip(e_sum) != e_sum));
`endif
    end
  endtask

  task automatic apply(input logic vld, input int prod, input logic rdy, input logic c);
    in_vld  = vld;
    in_prod = 15'(prod);
    out_rdy = rdy;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic vld, input int prod, input logic rdy, input logic c,
                     input logic e_vld, input int e_cnt, input int e_sum);
    vec_t v;
    v.vld = vld; v.prod = prod; v.rdy = rdy; v.clr = c;
    v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_sum = e_sum;
    vecs.push_back(v);
  endtask

  task automatic add_group(input int p[8], input logic rdy, input int esum);
    for (int k = 0; k < ACC_LEN; k++)
      add(1'b1, p[k], rdy, 1'b0, (k == ACC_LEN - 1), (k + 1) % ACC_LEN, esum);
  endtask

  // Reference model state: products of the open group and the pending result
  int   grp[$];
  logic pend;
  int   last_sum;

  initial begin
    int g[8];
    logic accepted;
    logic r_vld;
    int   r_prod;

    // ---------------- reset values
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 0, 0);
    check("reset_out_sum", int'(out_sum), 0);
    rst_n = 1'b1;

    // ---------------- directed vector table
    g = '{100, 200, -50, 1000, 10, 20, 30, -60};
    add_group(g, 1'b1, 1250);
    add(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0);

    for (int k = 0; k < 8; k++) g[k] = -16384;
    add_group(g, 1'b1, -131072);
    add(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0);

    // backpressure: result held five cycles while upstream keeps in_vld high
    for (int k = 0; k < 8; k++) g[k] = 1;
    add_group(g, 1'b0, 8);
    for (int k = 0; k < 4; k++) add(1'b1, 1, 1'b0, 1'b0, 1'b1, 0, 8);
    add(1'b1, 1, 1'b1, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1, 1'b1, 1'b0, 1'b0, 1, 0);
    add(1'b1, 7, 1'b1, 1'b0, 1'b0, 2, 0);
    add(1'b1, 7, 1'b1, 1'b0, 1'b0, 3, 0);
    add(1'b1, 7, 1'b1, 1'b1, 1'b0, 0, 0);
    add_group(g, 1'b1, 8);
    add(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0);

    // clr discards a pending result
    for (int k = 0; k < 8; k++) g[k] = 2;
    add_group(g, 1'b0, 16);
    add(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    add(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);

    // gapped input
    add(1'b1, 3, 1'b1, 1'b0, 1'b0, 1, 0);
    add(1'b0, 0, 1'b1, 1'b0, 1'b0, 1, 0);
    add(1'b0, 0, 1'b1, 1'b0, 1'b0, 1, 0);
    add(1'b1, 4, 1'b1, 1'b0, 1'b0, 2, 0);
    add(1'b0, 0, 1'b1, 1'b0, 1'b0, 2, 0);
    add(1'b1, 5, 1'b1, 1'b0, 1'b0, 3, 0);
    add(1'b1, 6, 1'b1, 1'b0, 1'b0, 4, 0);
    add(1'b1, 7, 1'b1, 1'b0, 1'b0, 5, 0);
    add(1'b1, 8, 1'b1, 1'b0, 1'b0, 6, 0);
    add(1'b1, 9, 1'b1, 1'b0, 1'b0, 7, 0);
    add(1'b1, 10, 1'b1, 1'b0, 1'b1, 0, 52);
    add(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0);

    for (int k = 0; k < 8; k++) g[k] = k + 1;
    add_group(g, 1'b1, 36);
    add(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0);

    for (int k = 0; k < 8; k++) g[k] = 16383;
    add_group(g, 1'b1, 131064);
    add(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].vld, vecs[i].prod, vecs[i].rdy, vecs[i].clr);
      check_outs($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_cnt, vecs[i].e_sum);
    end

    // ---------------- async reset while a result is held
    for (int k = 0; k < ACC_LEN; k++) apply(1'b1, 1, 1'b0, 1'b0);
    check_outs("pre_rst_hold", 1'b1, 0, 8);
    #2 rst_n = 1'b0;
    #1;
    check_outs("rst_hold", 1'b0, 0, 0);
    check("rst_hold_out_sum", int'(out_sum), 0);
    in_vld = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---------------- async reset mid-group, then a clean group
    for (int k = 0; k < 3; k++) apply(1'b1, 5, 1'b1, 1'b0);
    check_outs("pre_rst_mid", 1'b0, 3, 0);
    #2 rst_n = 1'b0;
    #1;
    check_outs("rst_mid", 1'b0, 0, 0);
    in_vld = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < ACC_LEN; k++) begin
      apply(1'b1, 3, 1'b1, 1'b0);
      check_outs($sformatf("post_rst%0d", k), (k == ACC_LEN - 1), (k + 1) % ACC_LEN, 24);
    end
    apply(1'b0, 0, 1'b1, 1'b0);
    check_outs("post_rst_idle", 1'b0, 0, 0);

    // ---------------- randomized traffic vs. group-sum model
    grp.delete();
    pend     = 1'b0;
    last_sum = 0;
    accepted = 1'b1;
    r_vld    = 1'b0;
    r_prod   = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!(r_vld && !accepted)) begin
        r_vld  = ($urandom_range(0, 9) < 7);
        r_prod = int'($urandom_range(0, 32767)) - 16384;
        if ($urandom_range(0, 7) == 0) r_prod = ($urandom_range(0, 1) != 0) ? 16383 : -16384;
      end
      in_vld  = r_vld;
      in_prod = 15'(r_prod);
      out_rdy = ($urandom_range(0, 9) < 6);
      clr     = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      accepted = 1'b0;
      if (clr) begin
        grp.delete();
        pend = 1'b0;
        accepted = 1'b1;
      end else if (!pend) begin
        if (in_vld) begin
          accepted = 1'b1;
          grp.push_back(r_prod);
          if (grp.size() == ACC_LEN) begin
            last_sum = grp.sum();
            pend     = 1'b1;
            grp.delete();
          end
        end
      end else if (out_rdy) begin
        pend = 1'b0;
      end
      #1;
      check_outs($sformatf("rnd%0d", cyc), pend, grp.size(), last_sum);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_mul_acc.md
Name: binary_mul_acc

Overview:
- Downstream accumulation stage for the signed 8x8 array multiplier.
- Consumes the registered 15-bit signed product stream and sums a fixed-length group of ACC_LEN products (dot-product / FIR tap sum).
- Presents each group total on a valid/ready output handshake.
- Stalls the upstream producer through in_rdy while a result is waiting to be taken.

Parameters:
- PROD_W, 15, width of the signed product input.
- ACC_LEN, 8, number of products summed per result; legal range 2..256.
- ACC_W, PROD_W+$clog2(ACC_LEN), width of the internal accumulator and of out_sum; 18 at the defaults.
- OUT_W, 16, width of the saturated output; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous abort; discards the partial sum and any pending result.
- in_vld  in  1  a product is present on in_prod.
- in_rdy  out  1  block accepts a product this cycle.
- in_prod  in  PROD_W  signed product, two's complement.
- out_vld  out  1  out_sum holds a completed group total.
- out_rdy  in  1  downstream takes the result.
- out_sum  out  ACC_W  signed group total; OUT_W wide when BINARY_MUL_ACC_SAT_EN is defined.
- out_cnt  out  8  number of products accepted so far in the current group.

Behaviour:
- Reset values: state=ACCUM, accumulator=0, out_cnt=0, out_vld=0, out_sum=0, in_rdy=1 (combinational from state).
- States:
  - ACCUM: in_rdy=1.
  - HOLD: in_rdy=0, out_vld=1.
- Accept rule: a transfer happens when in_vld & in_rdy.
  - in_prod is sign-extended to ACC_W and added to the accumulator.
  - out_cnt increments.
- Group end: the transfer with out_cnt==ACC_LEN-1 does all of the following in the same clock edge:
  - registers out_sum = acc + sext(in_prod);
  - clears the accumulator and out_cnt to 0;
  - moves to HOLD.
- Latency: out_vld rises 1 cycle after the last product is accepted.
- HOLD to ACCUM: on out_vld & out_rdy. out_vld drops the next cycle, and in_rdy=1 in that same next cycle.
- Throughput: at best ACC_LEN+1 cycles per result.
- Output stability: while out_vld=1 and out_rdy=0, out_sum is held stable. Upstream must hold its product (in_rdy=0) during this time.
- in_vld=0 in ACCUM: no change to the accumulator or out_cnt. Gaps in the input stream are allowed.
- clr:
  - Highest priority after reset.
  - Next state is ACCUM; accumulator=0, out_cnt=0, out_vld=0.
  - An in_prod arriving in the same cycle as clr is dropped.
  - A pending HOLD result is discarded.
- Arithmetic: two's complement, no overflow possible at ACC_W. Worst case ACC_LEN × (−2^(PROD_W−1)) fits exactly.
- ACC_LEN wrap: out_cnt never exceeds ACC_LEN-1.
- Reset mid-group: everything returns to reset values; no partial output is emitted.

Optional Feature:
- Macro: BINARY_MUL_ACC_SAT_EN.
- Defined:
  - out_sum is OUT_W wide.
  - The registered total clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - An extra output port out_sat (1 bit) is added. It is 1 alongside out_vld when clamping occurred, and resets to 0.
- Not defined:
  - out_sum is the full ACC_W result, with no clamping.
  - The out_sat port does not exist.

Decomposition:
- Shared package binary_mul_pkg holds:
  - PROD_W;
  - default ACC_LEN;
  - the state enum {ACCUM, HOLD};
  - a sat_clip function (value, width) used by the optional feature.
- One sub-module is natural: binary_mul_acc_sat, a combinational clamp from ACC_W to OUT_W with a flag, instantiated only under the macro.
- The rest is a single module.

Test Plan:
- Basic sum: ACC_LEN=4, products 100, 200, −50, 1000 back-to-back with out_rdy=1 → out_vld one cycle after the 4th, out_sum=1250; in_rdy=1 the following cycle.
- Negative extreme: ACC_LEN=8, eight products of −16384 → out_sum=−131072 (18'h20000), no wrap.
- Backpressure: complete a group of 8×1 with out_rdy=0 for 5 cycles → out_vld=1, out_sum=8 held and in_rdy=0 for all 5 cycles; in_vld held high with no products lost; next group starts on the cycle after out_rdy=1.
- Gapped input: ACC_LEN=4, products 3, idle, idle, 4, idle, 5, 6 → out_sum=18, out_cnt steps 1,1,1,2,2,3,0.
- clr and reset: after 3 products of 7, assert clr together with in_vld → out_cnt=0, accumulator=0, and the next 8 products of 1 give 8. Async rst_n low mid-group → out_vld=0, out_sum=0 immediately.
- SAT_EN: OUT_W=16, eight products of 16383 → out_sum=32767, out_sat=1. Eight products of −16384 → out_sum=−32768, out_sat=1. Products 1..8 → out_sum=36, out_sat=0.
